intctrl_pri: RTL and testbench
==============================

Name: intctrl_pri

Overview:
Parametrised successor to the 8-input interrupt controller on the PIC16F84 data bus. It handles NUM_CH request lines with per-channel mask and per-channel level/edge mode, plus fixed lowest-index-wins priority. Pending state and the winning vector are exposed through a byte-wide memory-mapped register window at BASE_ADDR. The block drives a single registered irq_o to the core.

Parameters:
NUM_CH, 16, number of interrupt channels; multiple of 8, range 8..32; NB = NUM_CH/8 register banks
BASE_ADDR, 16'h00E0, base of the 16-byte register window
ADDR_W, 16, bus address width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
address_i  input  ADDR_W  bus address
data_i  input  8  write data
we_i  input  1  write strobe, one access per cycle
re_i  input  1  read strobe
data_o  output  8  read data, registered
vector_i  input  NUM_CH  interrupt request lines, active-high
irq_o  output  1  interrupt request to core, registered

Behaviour:
- Reset (async, active-high): PEND, MASK and MODE cleared; GEN=0; data_o=8'h00; irq_o=0; edge/sync history flops=0.
- Register map (offset from BASE_ADDR; k = bank 0..3):
  0+k PEND: read pending[8k+7:8k]; write-1-to-clear.
  4+k MASK: R/W; 1 = enabled.
  8+k MODE: R/W; 0 = level, 1 = rising-edge.
  12 ID: read-only; 8'h80|idx of the lowest-index channel with pend&mask set; 8'h00 if none.
  13 CTRL: bit0 GEN (R/W); bit1 write-1 = ACK, which clears the pending bit of the current ID winner and reads 0.
  Other offsets and banks k>=NB: read 8'h00, writes ignored. Addresses outside the window: no effect, data_o holds its last value.
- Read latency: 1 cycle. data_o updates on the clock after re_i. Reads have no side effects.
- Sampling: s[i] = input after the front-end flop(s); p[i] = s[i] delayed 1 cycle.
  Level set condition: s[i]=1. Edge set condition: s[i]&~p[i].
- Pending is set regardless of MASK; MASK gates only ID and irq_o.
- Simultaneous set and clear (W1C or ACK) of the same bit in one cycle: set wins, bit stays 1.
- Level channel still asserted after a clear re-pends on the next cycle.
- ACK with no winner: no-op. ACK uses the winner computed from pre-write state.
- irq_o <= GEN & |(PEND & MASK), so irq_o lags PEND by 1 cycle. Writing MASK or GEN takes effect on irq_o 1 cycle after the write cycle.
- Latency without sync: vector_i rises → PEND visible the next cycle → irq_o one cycle later.
- MODE change: p[] is unaffected. If the line is already high, switching to edge mode causes no spurious set.
- Writes and reads in the same cycle (we_i & re_i): the read returns pre-write contents.

Optional Feature:
INTCTRL_SYNC_EN
- Defined: vector_i passes through a 2-flop synchroniser before s[], adding 2 cycles of latency to PEND and irq_o.
- Undefined: single sampling flop only; vector_i must be synchronous to clk.

Decomposition:
- Package intctrl_pkg: register offset constants (OFS_PEND=0, OFS_MASK=4, OFS_MODE=8, OFS_ID=12, OFS_CTRL=13), ID_VALID=8'h80, CTRL bit indices, MAX_CH=32.
- Sub-module intctrl_prio_enc: NUM_CH-bit request vector in → valid + 5-bit lowest-set index out. Purely combinational; reused by the ID read and the ACK logic.

Test Plan:
- Reset mid-operation: PEND=0x01, irq_o=1, assert reset → all registers read 0x00, irq_o=0 immediately.
- Level channel: MASK0=0x01, GEN=1, vector_i[0]=1 → PEND0=0x01, irq_o=1, ID=0x80. W1C 0x01 to BASE+0 while line high → PEND0 reads 0x01 again. Drop the line then W1C → PEND0=0x00, irq_o=0 two cycles later.
- Edge priority: MODE0=0xFF, MASK0=0xFF, GEN=1, raise vector_i[5] then vector_i[2] → ID=0x82. ACK (write 0x03 to BASE+13) → ID=0x85. ACK → ID=0x00, irq_o=0. Held-high lines do not re-pend.
- Masking: MASK=0x00 with vector_i[3] pulse in edge mode → PEND0=0x08, irq_o=0, ID=0x00. Set MASK0=0x08 → irq_o=1 one cycle later.
- Bank/boundary (NUM_CH=16): vector_i[15] edge → PEND1 reads 0x80, ID=0x8F. Read BASE+2 → 0x00. Write BASE+6 → ignored. Read address 16'h00F0 → data_o unchanged.
- Collision: edge on vector_i[1] in the same cycle as a W1C of bit 1 → PEND0 bit1 remains 1. With INTCTRL_SYNC_EN, PEND sets 3 cycles after the vector_i rise, versus 1 cycle without.

Source files
------------

// File: rtl/intctrl_pkg.sv
// Shared constants for the intctrl_pri interrupt controller.
// Register window offsets, ID encoding and CTRL bit positions.
package intctrl_pkg;

  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WIN_SIZE = 16;

  localparam logic [3:0] OFS_PEND = 4'd0;
  localparam logic [3:0] OFS_MASK = 4'd4;
  localparam logic [3:0] OFS_MODE = 4'd8;
  localparam logic [3:0] OFS_ID   = 4'd12;
  localparam logic [3:0] OFS_CTRL = 4'd13;

  localparam logic [DATA_W-1:0] ID_VALID = 8'h80;

  localparam int unsigned CTRL_GEN_BIT = 0;
  localparam int unsigned CTRL_ACK_BIT = 1;

endpackage

// File: rtl/intctrl_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module intctrl_prio_enc
  import intctrl_pkg::*;
#(
  parameter int unsigned NUM_CH = 16
) (
  input  logic [NUM_CH-1:0] req,
  output logic              valid_c,
  output logic [IDX_W-1:0]  idx_c
);

  // Scan from the top so the lowest set index is the last one assigned.
  always_comb begin
    valid_c = |req;
    idx_c   = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/intctrl_pri.sv
// Prioritised interrupt controller with a byte-wide register window at BASE_ADDR.
// Optional INTCTRL_SYNC_EN inserts a 2-flop synchroniser on vector_i.
module intctrl_pri
  import intctrl_pkg::*;
#(
  parameter int unsigned            NUM_CH    = 16,
  parameter int unsigned            ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]      BASE_ADDR = ADDR_W'('h00E0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [7:0]        data_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [7:0]        data_o,
  input  logic [NUM_CH-1:0] vector_i,
  output logic              irq_o
);

  localparam int unsigned NB = NUM_CH / 8;

  logic [NUM_CH-1:0] pend, mask, mode, p, s;
  logic [NUM_CH-1:0] pend_n, mask_n, mode_n, clr, set;
  logic              gen;
  logic [ADDR_W-1:0] off_full;
  logic [3:0]        off;
  logic [1:0]        bank;
  logic              in_win, wr, rd, ack;
  logic              win_valid;
  logic [IDX_W-1:0]  win_idx;
  logic [7:0]        rd_data;

`ifdef INTCTRL_SYNC_EN
  logic [NUM_CH-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= vector_i;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  // vector_i is synchronous to clk; the pending flop is the sampling point.
  assign s = vector_i;
`endif

  // Address below BASE_ADDR wraps to a large offset, so one compare bounds the window.
  assign off_full = address_i - BASE_ADDR;
  assign in_win   = off_full < ADDR_W'(WIN_SIZE);
  assign off      = off_full[3:0];
  assign bank     = off[1:0];
  assign wr       = we_i & in_win;
  assign rd       = re_i & in_win;
  assign ack      = wr && (off == OFS_CTRL) && data_i[CTRL_ACK_BIT];

  intctrl_prio_enc #(.NUM_CH(NUM_CH)) u_prio_enc (
    .req     (pend & mask),
    .valid_c (win_valid),
    .idx_c   (win_idx)
  );

  // Register writes, W1C and ACK clear; set from the front end wins over clear.
  always_comb begin
    clr    = '0;
    mask_n = mask;
    mode_n = mode;
    for (int k = 0; k < int'(NB); k++) begin
      if (wr && bank == 2'(k)) begin
        case (off[3:2])
          OFS_PEND[3:2]: clr[8*k +: 8]    = data_i;
          OFS_MASK[3:2]: mask_n[8*k +: 8] = data_i;
          OFS_MODE[3:2]: mode_n[8*k +: 8] = data_i;
          default: ;
        endcase
      end
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ack && win_valid && win_idx == IDX_W'(i)) clr[i] = 1'b1;
    end
    set    = s & (~mode | ~p);
    pend_n = (pend & ~clr) | set;
  end

  // Read mux over pre-write state; unimplemented banks and offsets read zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < int'(NB); k++) begin
      if (bank == 2'(k)) begin
        case (off[3:2])
          OFS_PEND[3:2]: rd_data = pend[8*k +: 8];
          OFS_MASK[3:2]: rd_data = mask[8*k +: 8];
          OFS_MODE[3:2]: rd_data = mode[8*k +: 8];
          default: ;
        endcase
      end
    end
    if (off == OFS_ID && win_valid) rd_data = ID_VALID | 8'(win_idx);
    if (off == OFS_CTRL)            rd_data = 8'(gen);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= '0;
      mask   <= '0;
      mode   <= '0;
      p      <= '0;
      gen    <= 1'b0;
      data_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      pend  <= pend_n;
      mask  <= mask_n;
      mode  <= mode_n;
      p     <= s;
      irq_o <= gen & |(pend & mask);
      if (wr && off == OFS_CTRL) gen <= data_i[CTRL_GEN_BIT];
      if (rd) data_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_intctrl_pri.sv
// Directed self-checking bench for intctrl_pri (NUM_CH=16, BASE_ADDR=16'h00E0).
module tb_intctrl_pri;

`ifdef INTCTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        we_i, re_i;
  logic [7:0]  data_o;
  logic [15:0] vector_i;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  intctrl_pri #(.NUM_CH(16), .ADDR_W(16), .BASE_ADDR(16'h00E0)) dut (
    .clk       (clk),
    .reset     (reset),
    .address_i (address_i),
    .data_i    (data_i),
    .we_i      (we_i),
    .re_i      (re_i),
    .data_o    (data_o),
    .vector_i  (vector_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    address_i = a; data_i = d; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    address_i = a; re_i = 1'b1;
    @(negedge clk);
    re_i = 1'b0;
    d = data_o;
  endtask

  task automatic settle();
    repeat (SYNC_LAT + 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vector_i = '0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_pend0: got %h want 00", d); end
    bus_read(16'h00E4, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mask0: got %h want 00", d); end
    bus_read(16'h00E8, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mode0: got %h want 00", d); end
    bus_read(16'h00EC, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_id: got %h want 00", d); end
    bus_read(16'h00ED, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", d); end
  endtask

  task automatic test_level();
    logic [7:0] d;
    do_reset();
    bus_write(16'h00E4, 8'h01);
    bus_write(16'h00ED, 8'h01);
    vector_i[0] = 1'b1;
    settle();
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL level_pend: got %h want 01", d); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL level_irq: got %b want 1", irq_o); end
    bus_read(16'h00EC, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL level_id: got %h want 80", d); end
    bus_write(16'h00E0, 8'h01);
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL level_repend: got %h want 01", d); end
    vector_i[0] = 1'b0;
    settle();
    bus_write(16'h00E0, 8'h01);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL level_irq_lag: got %b want 1", irq_o); end
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL level_cleared: got %h want 00", d); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL level_irq_drop: got %b want 0", irq_o); end
  endtask

  task automatic test_edge_priority();
    logic [7:0] d;
    do_reset();
    bus_write(16'h00E8, 8'hFF);
    bus_write(16'h00E4, 8'hFF);
    bus_write(16'h00ED, 8'h01);
    vector_i[5] = 1'b1;
    @(negedge clk);
    vector_i[2] = 1'b1;
    settle();
    bus_read(16'h00EC, d);
    checks++; if (d !== 8'h82) begin errors++; $display("FAIL edge_id_first: got %h want 82", d); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL edge_irq: got %b want 1", irq_o); end
    bus_write(16'h00ED, 8'h03);
    bus_read(16'h00EC, d);
    checks++; if (d !== 8'h85) begin errors++; $display("FAIL edge_id_second: got %h want 85", d); end
    bus_write(16'h00ED, 8'h03);
    bus_read(16'h00EC, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_id_none: got %h want 00", d); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL edge_irq_off: got %b want 0", irq_o); end
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_no_repend: got %h want 00", d); end
    bus_read(16'h00ED, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL edge_ctrl_read: got %h want 01", d); end
    bus_write(16'h00ED, 8'h03);
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_ack_noop: got %h want 00", d); end
  endtask

  task automatic test_masking();
    logic [7:0] d;
    do_reset();
    bus_write(16'h00E8, 8'hFF);
    bus_write(16'h00ED, 8'h01);
    vector_i[3] = 1'b1;
    @(negedge clk);
    vector_i[3] = 1'b0;
    settle();
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL mask_pend: got %h want 08", d); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b want 0", irq_o); end
    bus_read(16'h00EC, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mask_id: got %h want 00", d); end
    bus_write(16'h00E4, 8'h08);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mask_irq_lag: got %b want 0", irq_o); end
    @(negedge clk);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL mask_irq_on: got %b want 1", irq_o); end
  endtask

  task automatic test_rw_same_cycle();
    logic [7:0] d;
    do_reset();
    @(negedge clk);
    address_i = 16'h00E4; data_i = 8'h55; we_i = 1'b1; re_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; re_i = 1'b0;
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rw_prewrite: got %h want 00", data_o); end
    bus_read(16'h00E4, d);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL rw_postwrite: got %h want 55", d); end
  endtask

  task automatic test_bank_boundary();
    logic [7:0] d;
    do_reset();
    bus_write(16'h00E9, 8'h80);
    bus_write(16'h00E5, 8'h80);
    bus_write(16'h00ED, 8'h01);
    vector_i[15] = 1'b1;
    settle();
    bus_read(16'h00EC, d);
    checks++; if (d !== 8'h8F) begin errors++; $display("FAIL bank_id: got %h want 8f", d); end
    bus_read(16'h00E2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bank_absent_read: got %h want 00", d); end
    bus_write(16'h00E6, 8'hFF);
    bus_read(16'h00E6, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bank_absent_write: got %h want 00", d); end
    bus_read(16'h00EE, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bank_reserved: got %h want 00", d); end
    bus_read(16'h00E1, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL bank_pend1: got %h want 80", d); end
    bus_read(16'h00F0, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL bank_above_window: got %h want 80", d); end
    bus_read(16'h00DF, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL bank_below_window: got %h want 80", d); end
  endtask

  task automatic test_mode_switch();
    logic [7:0] d;
    do_reset();
    vector_i[4] = 1'b1;
    settle();
    bus_write(16'h00E8, 8'h10);
    bus_write(16'h00E0, 8'h10);
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mode_no_spurious: got %h want 00", d); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    do_reset();
    bus_write(16'h00E8, 8'h02);
    @(negedge clk);
    vector_i[1] = 1'b1;
    repeat (SYNC_LAT) @(negedge clk);
    address_i = 16'h00E0; data_i = 8'h02; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL collision_set_wins: got %h want 02", d); end
  endtask

  task automatic test_latency();
    logic exp;
    do_reset();
    bus_write(16'h00E4, 8'h40);
    bus_write(16'h00ED, 8'h01);
    vector_i[6] = 1'b1;
    for (int c = 1; c <= SYNC_LAT + 3; c++) begin
      @(negedge clk);
      exp = (c >= SYNC_LAT + 2);
      checks++; if (irq_o !== exp) begin errors++; $display("FAIL latency_cycle%0d: got %b want %b", c, irq_o, exp); end
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] d;
    do_reset();
    bus_write(16'h00E4, 8'h01);
    bus_write(16'h00ED, 8'h01);
    vector_i[0] = 1'b1;
    settle();
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL midop_pend: got %h want 01", d); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL midop_irq: got %b want 1", irq_o); end
    @(negedge clk);
    #2;
    reset = 1'b1; vector_i = '0;
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL midop_async_irq: got %b want 0", irq_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL midop_async_data: got %h want 00", data_o); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(16'h00E0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midop_pend_clr: got %h want 00", d); end
    bus_read(16'h00E4, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midop_mask_clr: got %h want 00", d); end
    bus_read(16'h00ED, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL midop_ctrl_clr: got %h want 00", d); end
  endtask

  initial begin
    reset = 1'b1; address_i = '0; data_i = '0; we_i = 1'b0; re_i = 1'b0; vector_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_level();
    test_edge_priority();
    test_masking();
    test_rw_same_cycle();
    test_bank_boundary();
    test_mode_switch();
    test_collision();
    test_latency();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
